// File: rtl/midi_pkg.sv
// Shared MIDI scheduler definitions: FSM state encoding, byte type, status-nibble
// constants and small status/data helpers used by the interface and the scheduler.
package midi_pkg;

  typedef logic [7:0] midi_byte_t;

  typedef enum logic [1:0] {
    StIdle,
    StSendSt,
    StSendD1,
    StSendD2
  } midi_state_e;

  localparam logic [3:0] ST_PROG_CHG = 4'hC;
  localparam logic [3:0] ST_CH_PRESS = 4'hD;
  localparam logic [3:0] ST_SYSTEM   = 4'hF;

  // Channel-voice status only: bit7 set and not a system message.
  function automatic logic status_ok(midi_byte_t s);
    return s[7] && (s[7:4] != ST_SYSTEM);
  endfunction

  // Program change and channel pressure carry a single data byte.
  function automatic logic is_two_byte(midi_byte_t s);
    return (s[7:4] == ST_PROG_CHG) || (s[7:4] == ST_CH_PRESS);
  endfunction

  function automatic midi_byte_t data_byte(midi_byte_t b);
    return {1'b0, b[6:0]};
  endfunction

endpackage

// File: rtl/midi_tx_sched_if.sv
// Requester/serializer bundle for midi_tx_sched.
//   master: requester side plus serializer ready (drives req_*, tx_ready)
//   slave : scheduler side (drives req_ack, tx_data, tx_valid, busy, drop_err)
interface midi_tx_sched_if #(
  parameter int unsigned N_REQ = 4
);
  import midi_pkg::*;

  logic       [N_REQ-1:0] req_valid;
  midi_byte_t [N_REQ-1:0] req_status;
  midi_byte_t [N_REQ-1:0] req_data1;
  midi_byte_t [N_REQ-1:0] req_data2;
  logic       [N_REQ-1:0] req_ack;
  midi_byte_t             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   busy;
  logic                   drop_err;

  modport master (
    output req_valid, req_status, req_data1, req_data2, tx_ready,
    input  req_ack, tx_data, tx_valid, busy, drop_err
  );

  modport slave (
    input  req_valid, req_status, req_data1, req_data2, tx_ready,
    output req_ack, tx_data, tx_valid, busy, drop_err
  );

endinterface

// File: rtl/midi_rr_arbiter.sv
// Round-robin requester selection. Searches req_i starting at ptr_i and wrapping;
// returns the first hit as one-hot gnt_o and binary gnt_idx_o; any_o flags a hit.
module midi_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IdxW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]  gnt_idx_o,
  output logic             any_o
);

  always_comb begin
    int unsigned idx;
    logic [IdxW-1:0] idx_w;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx   = (32'(ptr_i) + k) % N_REQ;
      idx_w = IdxW'(idx);
      if (!any_o && req_i[idx_w]) begin
        any_o        = 1'b1;
        gnt_idx_o    = idx_w;
        gnt_o[idx_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/midi_tx_sched.sv
// MIDI message scheduler: picks one pending requester round-robin, captures its
// status/data bytes and streams them to a byte serializer over a valid/ready link.
// Optional running status suppresses a repeated status byte; invalid statuses are
// acked and dropped with a drop_err pulse.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   bus_io : requester inputs, req_ack, tx_data/tx_valid/tx_ready, busy, drop_err
module midi_tx_sched
  import midi_pkg::*;
#(
  parameter int unsigned N_REQ             = 4,
  parameter bit          RUNNING_STATUS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  midi_tx_sched_if.slave  bus_io
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  midi_state_e      state_q, state_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  midi_byte_t       st_q, st_d;
  midi_byte_t       d1_q, d1_d;
  midi_byte_t       d2_q, d2_d;
  logic             three_q, three_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             drop_q, drop_d;
  midi_byte_t       last_st_q, last_st_d;
  logic             last_vld_q, last_vld_d;

  logic [N_REQ-1:0] gnt;
  logic [IdxW-1:0]  gnt_idx;
  logic             gnt_any;
  midi_byte_t       sel_st;

  midi_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i     (bus_io.req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  assign sel_st = bus_io.req_status[gnt_idx];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    st_d       = st_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    three_d    = three_q;
    ack_d      = '0;
    drop_d     = 1'b0;
    last_st_d  = last_st_q;
    last_vld_d = last_vld_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          ack_d = gnt;
          ptr_d = (gnt_idx == IdxW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (!status_ok(sel_st)) begin
            drop_d = 1'b1;
          end else begin
            st_d    = sel_st;
            d1_d    = bus_io.req_data1[gnt_idx];
            d2_d    = bus_io.req_data2[gnt_idx];
            three_d = !is_two_byte(sel_st);
            state_d = (RUNNING_STATUS_EN && last_vld_q && (last_st_q == sel_st)) ?
                      StSendD1 : StSendSt;
          end
        end
      end
      StSendSt: begin
        if (bus_io.tx_ready) begin
          last_st_d  = st_q;
          last_vld_d = 1'b1;
          state_d    = StSendD1;
        end
      end
      StSendD1: begin
        if (bus_io.tx_ready) state_d = three_q ? StSendD2 : StIdle;
      end
      StSendD2: begin
        if (bus_io.tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      st_q       <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      three_q    <= 1'b0;
      ack_q      <= '0;
      drop_q     <= 1'b0;
      last_st_q  <= '0;
      last_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      st_q       <= st_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      three_q    <= three_d;
      ack_q      <= ack_d;
      drop_q     <= drop_d;
      last_st_q  <= last_st_d;
      last_vld_q <= last_vld_d;
    end
  end

  // Outputs derive from state so reset clears them without waiting for a clock.
  always_comb begin
    bus_io.tx_data = '0;
    unique case (state_q)
      StSendSt: bus_io.tx_data = st_q;
      StSendD1: bus_io.tx_data = data_byte(d1_q);
      StSendD2: bus_io.tx_data = data_byte(d2_q);
      default:  bus_io.tx_data = '0;
    endcase
  end

  assign bus_io.tx_valid = (state_q != StIdle);
  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.req_ack  = ack_q;
  assign bus_io.drop_err = drop_q;

endmodule

// File: tb/tb_midi_tx_sched.sv
module tb_midi_tx_sched;
  import midi_pkg::*;

  logic clk;
  logic rst;
  logic rs0_en;

  midi_tx_sched_if #(.N_REQ(4)) bus ();
  midi_tx_sched_if #(.N_REQ(4)) bus2 ();

  midi_tx_sched #(.N_REQ(4), .RUNNING_STATUS_EN(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  midi_tx_sched #(.N_REQ(4), .RUNNING_STATUS_EN(1'b0)) dut_nrs (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus2)
  );

  // Second instance mirrors the first one's stimulus only while enabled.
  assign bus2.req_valid  = rs0_en ? bus.req_valid : 4'b0000;
  assign bus2.req_status = bus.req_status;
  assign bus2.req_data1  = bus.req_data1;
  assign bus2.req_data2  = bus.req_data2;
  assign bus2.tx_ready   = bus.tx_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  midi_byte_t q[$];
  midi_byte_t q2[$];
  int ackq[$];

  always @(posedge clk) begin
    if (rst && bus.tx_valid && bus.tx_ready) q.push_back(bus.tx_data);
    if (rst && bus2.tx_valid && bus2.tx_ready) q2.push_back(bus2.tx_data);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (bus.req_ack[k]) ackq.push_back(k);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!bus.busy && !bus2.busy) done = 1;
    end
    check("idle_reached", 32'(done), 1);
  endtask

  task automatic send_msg(input int idx, input midi_byte_t st, input midi_byte_t d1,
                          input midi_byte_t d2, output logic drop);
    bit got = 0;
    drop = 1'b0;
    @(negedge clk);
    bus.req_status[idx] = st;
    bus.req_data1[idx]  = d1;
    bus.req_data2[idx]  = d2;
    bus.req_valid[idx]  = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ack[idx]) begin
        got = 1;
        drop = bus.drop_err;
        bus.req_valid[idx] = 1'b0;
      end
    end
    check("ack_seen", 32'(got), 1);
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    midi_byte_t st, d1, d2;
    int         n;
    midi_byte_t b0, b1, b2;
    logic       drop;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic dr;
    midi_byte_t eb[3];

    vecs[0] = '{8'h90, 8'h3C, 8'h64, 2, 8'h3C, 8'h64, 8'h00, 1'b0};
    vecs[1] = '{8'hC5, 8'hA7, 8'h11, 2, 8'hC5, 8'h27, 8'h00, 1'b0};
    vecs[2] = '{8'hC5, 8'h05, 8'h00, 1, 8'h05, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'h45, 8'h11, 8'h22, 0, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{8'hF8, 8'h11, 8'h22, 0, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[5] = '{8'hB0, 8'h87, 8'hFF, 3, 8'hB0, 8'h07, 8'h7F, 1'b0};
    vecs[6] = '{8'hE1, 8'h00, 8'h40, 3, 8'hE1, 8'h00, 8'h40, 1'b0};
    vecs[7] = '{8'hD2, 8'h90, 8'h12, 2, 8'hD2, 8'h10, 8'h00, 1'b0};
    vecs[8] = '{8'h7F, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[9] = '{8'h80, 8'hBC, 8'h80, 3, 8'h80, 8'h3C, 8'h00, 1'b0};

    rs0_en         = 1'b0;
    rst            = 1'b0;
    bus.req_valid  = '0;
    bus.req_status = '0;
    bus.req_data1  = '0;
    bus.req_data2  = '0;
    bus.tx_ready   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ack", 32'(bus.req_ack), 0);
    check("rst_drop", 32'(bus.drop_err), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    rst = 1'b1;

    // Cycle-exact basic note-on
    @(negedge clk);
    bus.req_status[0] = 8'h90;
    bus.req_data1[0]  = 8'h3C;
    bus.req_data2[0]  = 8'h64;
    bus.req_valid[0]  = 1'b1;
    @(negedge clk);
    check("c1_ack", 32'(bus.req_ack), 32'h1);
    check("c1_tx_valid", 32'(bus.tx_valid), 1);
    check("c1_tx_data", 32'(bus.tx_data), 32'h90);
    check("c1_drop", 32'(bus.drop_err), 0);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("c2_ack", 32'(bus.req_ack), 0);
    check("c2_tx_data", 32'(bus.tx_data), 32'h3C);
    @(negedge clk);
    check("c3_tx_valid", 32'(bus.tx_valid), 1);
    check("c3_tx_data", 32'(bus.tx_data), 32'h64);
    @(negedge clk);
    check("c4_tx_valid", 32'(bus.tx_valid), 0);
    check("c4_busy", 32'(bus.busy), 0);

    // Table of single messages, rotating through requesters
    for (int v = 0; v < 10; v++) begin
      q.delete();
      send_msg(v % 4, vecs[v].st, vecs[v].d1, vecs[v].d2, dr);
      eb[0] = vecs[v].b0;
      eb[1] = vecs[v].b1;
      eb[2] = vecs[v].b2;
      check($sformatf("vec%0d_drop", v), 32'(dr), 32'(vecs[v].drop));
      check($sformatf("vec%0d_nbytes", v), 32'(q.size()), 32'(vecs[v].n));
      for (int b = 0; b < vecs[v].n; b++)
        check($sformatf("vec%0d_byte%0d", v, b), 32'(q[b]), 32'(eb[b]));
    end

    // Stall in the first data byte
    do_reset();
    q.delete();
    @(negedge clk);
    bus.req_status[1] = 8'h90;
    bus.req_data1[1]  = 8'h3C;
    bus.req_data2[1]  = 8'h64;
    bus.req_valid[1]  = 1'b1;
    @(negedge clk);
    check("stall_ack", 32'(bus.req_ack), 32'h2);
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    check("stall_d1_data", 32'(bus.tx_data), 32'h3C);
    bus.tx_ready = 1'b0;
    begin
      bit stable = 1;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (!bus.tx_valid || bus.tx_data != 8'h3C || !bus.busy) stable = 0;
      end
      check("stall_stable", 32'(stable), 1);
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    check("stall_d2_data", 32'(bus.tx_data), 32'h64);
    wait_idle();
    check("stall_nbytes", 32'(q.size()), 3);
    check("stall_b2", 32'(q[2]), 32'h64);

    // Reset during the first data byte (running-status message)
    @(negedge clk);
    bus.req_valid[1] = 1'b1;
    @(negedge clk);
    check("rmid_ack", 32'(bus.req_ack), 32'h2);
    bus.req_valid[1] = 1'b0;
    check("rmid_rs_data", 32'(bus.tx_data), 32'h3C);
    #2 rst = 1'b0;
    #1;
    check("rmid_tx_valid", 32'(bus.tx_valid), 0);
    check("rmid_busy", 32'(bus.busy), 0);
    check("rmid_tx_data", 32'(bus.tx_data), 0);
    check("rmid_ack0", 32'(bus.req_ack), 0);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    send_msg(1, 8'h90, 8'h3C, 8'h64, dr);
    check("rpost_nbytes", 32'(q.size()), 3);
    check("rpost_status", 32'(q[0]), 32'h90);

    // Round robin, all requesters held
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.req_status[k] = 8'h90;
      bus.req_data1[k]  = 8'h3C;
      bus.req_data2[k]  = 8'h64;
    end
    ackq.delete();
    @(negedge clk);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 100 && ackq.size() < 5; c++) @(negedge clk);
    bus.req_valid = 4'b0000;
    wait_idle();
    begin
      int exp_a[5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) check($sformatf("rr1111_%0d", i), 32'(ackq[i]), 32'(exp_a[i]));
    end
    do_reset();
    ackq.delete();
    @(negedge clk);
    bus.req_valid = 4'b0101;
    for (int c = 0; c < 100 && ackq.size() < 4; c++) @(negedge clk);
    bus.req_valid = 4'b0000;
    wait_idle();
    begin
      int exp_b[4] = '{0, 2, 0, 2};
      for (int i = 0; i < 4; i++) check($sformatf("rr0101_%0d", i), 32'(ackq[i]), 32'(exp_b[i]));
    end

    // Running status on vs off
    do_reset();
    rs0_en = 1'b1;
    q.delete();
    q2.delete();
    send_msg(0, 8'h90, 8'h3C, 8'h64, dr);
    send_msg(0, 8'h90, 8'h3C, 8'h64, dr);
    rs0_en = 1'b0;
    check("rs1_nbytes", 32'(q.size()), 5);
    check("rs1_b3", 32'(q[3]), 32'h3C);
    check("rs0_nbytes", 32'(q2.size()), 6);
    check("rs0_b3", 32'(q2[3]), 32'h90);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
